// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if
//   Bundles every handshake and bus signal around the memory-port arbiter.
//   The signals fall into three groups:
//     - the instruction-fetch requester (if_*)
//     - the load/store requester (dm_*)
//     - the single-ported memory (mem_*)
//   It also carries the pipeline STALL and the bus_err pulse.
//
// Modports
//   master : the arbiter.
//            Drives acks, read data, mem_* requests, STALL and bus_err.
//   slave  : the environment (pipeline stages plus memory model).
//            Drives requests, addresses, write data, mem_rdata and mem_ack.
interface mem_port_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic [DW-1:0] if_rdata;
  logic          if_ack;

  logic          dm_req;
  logic          dm_we;
  logic [AW-1:0] dm_addr;
  logic [DW-1:0] dm_wdata;
  logic [DW-1:0] dm_rdata;
  logic          dm_ack;

  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_ack;

  logic          STALL;
  logic          bus_err;

  modport master (
    input  if_req, if_addr,
    input  dm_req, dm_we, dm_addr, dm_wdata,
    input  mem_rdata, mem_ack,
    output if_rdata, if_ack, dm_rdata, dm_ack,
    output mem_req, mem_we, mem_addr, mem_wdata,
    output STALL, bus_err
  );

  modport slave (
    output if_req, if_addr,
    output dm_req, dm_we, dm_addr, dm_wdata,
    output mem_rdata, mem_ack,
    input  if_rdata, if_ack, dm_rdata, dm_ack,
    input  mem_req, mem_we, mem_addr, mem_wdata,
    input  STALL, bus_err
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-ported unified memory between instruction fetch (IF)
//   and load/store (DM).
//   - Each access is a req/ack transaction: one grant, one memory
//     request held until mem_ack, then a one-cycle ack to the requester.
//   - DM has priority. After STARVE_MAX consecutive DM grants with IF
//     waiting, the next contested slot goes to IF.
//   - STALL (active-low) freezes the pipeline while any request is
//     outstanding.
//
// Ports
//   Clk  : clock, rising edge
//   Clrn : synchronous active-low reset
//   bus  : mem_port_arbiter_if.master, which carries
//            if_*     : fetch requester
//            dm_*     : load/store requester
//            mem_*    : memory port
//            STALL    : pipeline freeze, active-low
//            bus_err  : timeout pulse
//
// Build option
//   ARB_TIMEOUT_EN : when defined, a BUSY state that sees no mem_ack for
//                    TIMEOUT cycles is abandoned:
//                      - the requester gets its ack with rdata = 0
//                      - bus_err pulses in the same cycle
//                    When undefined, BUSY waits forever and bus_err is 0.
module mem_port_arbiter #(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int STARVE_MAX = 3,
  parameter int TIMEOUT    = 15
) (
  input logic               Clk,
  input logic               Clrn,
  mem_port_arbiter_if.master bus
);
  localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {IDLE, IF_BUSY, DM_BUSY} state_t;

  state_t        state_reg, state_next;
  logic [SW-1:0] starve_reg, starve_next;
  logic          mem_req_reg, mem_req_next;
  logic          mem_we_reg, mem_we_next;
  logic [AW-1:0] mem_addr_reg, mem_addr_next;
  logic [DW-1:0] mem_wdata_reg, mem_wdata_next;
  logic          if_ack_reg, if_ack_next;
  logic          dm_ack_reg, dm_ack_next;
  logic [DW-1:0] if_rdata_reg, if_rdata_next;
  logic [DW-1:0] dm_rdata_reg, dm_rdata_next;
  logic          dm_grant, if_grant;
  logic          done;
  logic [DW-1:0] done_data;

`ifdef ARB_TIMEOUT_EN
  localparam int WW = (TIMEOUT < 15) ? 4 : $clog2(TIMEOUT + 1);
  logic [WW-1:0] wait_reg, wait_next;
  logic          bus_err_reg, bus_err_next;
`endif

  always_comb begin
    state_next     = state_reg;
    starve_next    = starve_reg;
    mem_req_next   = mem_req_reg;
    mem_we_next    = mem_we_reg;
    mem_addr_next  = mem_addr_reg;
    mem_wdata_next = mem_wdata_reg;
    if_ack_next    = 1'b0;
    dm_ack_next    = 1'b0;
    if_rdata_next  = if_rdata_reg;
    dm_rdata_next  = dm_rdata_reg;
    dm_grant       = 1'b0;
    if_grant       = 1'b0;
    done           = 1'b0;
    done_data      = bus.mem_rdata;
`ifdef ARB_TIMEOUT_EN
    wait_next      = wait_reg;
    bus_err_next   = 1'b0;
`endif

    unique case (state_reg)
      IDLE: begin
        // DM wins unless IF has already waited through STARVE_MAX DM grants.
        dm_grant = bus.dm_req && !(bus.if_req && starve_reg == SW'(STARVE_MAX));
        if_grant = !dm_grant && bus.if_req;
        if (dm_grant) begin
          state_next     = DM_BUSY;
          mem_req_next   = 1'b1;
          mem_we_next    = bus.dm_we;
          mem_addr_next  = bus.dm_addr;
          mem_wdata_next = bus.dm_wdata;
          if (bus.if_req && starve_reg != SW'(STARVE_MAX))
            starve_next = starve_reg + 1'b1;
        end else if (if_grant) begin
          state_next     = IF_BUSY;
          mem_req_next   = 1'b1;
          mem_we_next    = 1'b0;
          mem_addr_next  = bus.if_addr;
          mem_wdata_next = '0;
          starve_next    = '0;
        end
`ifdef ARB_TIMEOUT_EN
        if (dm_grant || if_grant)
          wait_next = '0;
`endif
      end
      IF_BUSY, DM_BUSY: begin
        if (bus.mem_ack) begin
          done = 1'b1;
`ifdef ARB_TIMEOUT_EN
        end else if (wait_reg == WW'(TIMEOUT - 1)) begin
          // mem_ack has precedence, so this branch only fires without it.
          done         = 1'b1;
          done_data    = '0;
          bus_err_next = 1'b1;
        end else begin
          wait_next = wait_reg + 1'b1;
`endif
        end
        if (done) begin
          state_next   = IDLE;
          mem_req_next = 1'b0;
          mem_we_next  = 1'b0;
          if (state_reg == IF_BUSY) begin
            if_ack_next   = 1'b1;
            if_rdata_next = done_data;
          end else begin
            dm_ack_next   = 1'b1;
            dm_rdata_next = done_data;
          end
        end
      end
      default: state_next = IDLE;
    endcase

    // The starvation streak only counts while IF is actually waiting.
    if (!bus.if_req)
      starve_next = '0;
  end

  always_ff @(posedge Clk) begin
    if (!Clrn) begin
      state_reg     <= IDLE;
      starve_reg    <= '0;
      mem_req_reg   <= 1'b0;
      mem_we_reg    <= 1'b0;
      mem_addr_reg  <= '0;
      mem_wdata_reg <= '0;
      if_ack_reg    <= 1'b0;
      dm_ack_reg    <= 1'b0;
      if_rdata_reg  <= '0;
      dm_rdata_reg  <= '0;
`ifdef ARB_TIMEOUT_EN
      wait_reg      <= '0;
      bus_err_reg   <= 1'b0;
`endif
    end else begin
      state_reg     <= state_next;
      starve_reg    <= starve_next;
      mem_req_reg   <= mem_req_next;
      mem_we_reg    <= mem_we_next;
      mem_addr_reg  <= mem_addr_next;
      mem_wdata_reg <= mem_wdata_next;
      if_ack_reg    <= if_ack_next;
      dm_ack_reg    <= dm_ack_next;
      if_rdata_reg  <= if_rdata_next;
      dm_rdata_reg  <= dm_rdata_next;
`ifdef ARB_TIMEOUT_EN
      wait_reg      <= wait_next;
      bus_err_reg   <= bus_err_next;
`endif
    end
  end

  assign bus.mem_req   = mem_req_reg;
  assign bus.mem_we    = mem_we_reg;
  assign bus.mem_addr  = mem_addr_reg;
  assign bus.mem_wdata = mem_wdata_reg;
  assign bus.if_ack    = if_ack_reg;
  assign bus.dm_ack    = dm_ack_reg;
  assign bus.if_rdata  = if_rdata_reg;
  assign bus.dm_rdata  = dm_rdata_reg;
  // A requester stops stalling in the cycle its ack is presented.
  assign bus.STALL = ~((bus.if_req & ~if_ack_reg) | (bus.dm_req & ~dm_ack_reg));
`ifdef ARB_TIMEOUT_EN
  assign bus.bus_err = bus_err_reg;
`else
  assign bus.bus_err = 1'b0;
`endif
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
//   Scoreboard bench for mem_port_arbiter.
//   - The expected memory transaction (owner, we, addr, wdata, returned
//     rdata) is pushed when a request is driven.
//   - It is popped and compared when the arbiter raises mem_req.
//   - The requester ack and rdata are then checked after the bench's
//     memory model answers.
module tb_mem_port_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;

  logic Clk  = 1'b0;
  logic Clrn = 1'b0;
  always #5 Clk = ~Clk;

  mem_port_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  mem_port_arbiter #(
    .AW(AW), .DW(DW), .STARVE_MAX(3), .TIMEOUT(15)
  ) dut (
    .Clk (Clk),
    .Clrn(Clrn),
    .bus (bus)
  );

  typedef struct packed {
    logic          is_dm;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
  } txn_t;

  txn_t exp_q[$];
  txn_t cur;
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic push(input logic is_dm, input logic we, input logic [AW-1:0] addr,
                      input logic [DW-1:0] wdata, input logic [DW-1:0] rdata);
    txn_t t;
    t.is_dm = is_dm; t.we = we; t.addr = addr; t.wdata = wdata; t.rdata = rdata;
    exp_q.push_back(t);
  endtask

  // Wait (bounded) for mem_req, then compare the presented request with the scoreboard.
  task automatic start_txn();
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (bus.mem_req) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
    check("grant_seen", seen, 1'b1);
    check("queue_nonempty", exp_q.size() != 0, 1'b1);
    if (exp_q.size() == 0) begin
      cur = '0;
      return;
    end
    cur = exp_q.pop_front();
    check("mem_addr", bus.mem_addr, cur.addr);
    check("mem_we", bus.mem_we, cur.we);
    if (cur.we)
      check("mem_wdata", bus.mem_wdata, cur.wdata);
  endtask

  // Hold off mem_ack for lat more cycles, answer, then check the ack pulse and read data.
  task automatic finish_txn(input int lat, input bit hold);
    logic req_now;
    for (int i = 0; i < lat; i++) begin
      tick();
      check("mem_req_hold", bus.mem_req, 1'b1);
      check("mem_addr_hold", bus.mem_addr, cur.addr);
      check("bus_err_idle", bus.bus_err, 1'b0);
      req_now = cur.is_dm ? bus.dm_req : bus.if_req;
      if (!hold && req_now)
        check("stall_busy", bus.STALL, 1'b0);
    end
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = cur.rdata;
    tick();
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = $urandom;
    check("mem_req_drop", bus.mem_req, 1'b0);
    check("if_ack", bus.if_ack, !cur.is_dm);
    check("dm_ack", bus.dm_ack, cur.is_dm);
    check("bus_err_ok", bus.bus_err, 1'b0);
    if (!cur.we) begin
      if (cur.is_dm) check("dm_rdata", bus.dm_rdata, cur.rdata);
      else           check("if_rdata", bus.if_rdata, cur.rdata);
    end
    if (!hold) begin
      check("stall_ack", bus.STALL, 1'b1);
      if (cur.is_dm) bus.dm_req = 1'b0;
      else           bus.if_req = 1'b0;
    end
    $display("txn %s we=%0d addr=0x%08h rdata=0x%08h", cur.is_dm ? "DM" : "IF",
             cur.we, cur.addr, cur.is_dm ? bus.dm_rdata : bus.if_rdata);
    tick();
    check("if_ack_pulse", bus.if_ack, 1'b0);
    check("dm_ack_pulse", bus.dm_ack, 1'b0);
  endtask

  // Both requesters held: grants go DM,DM,DM,IF repeating; a trailing DM grant closes the run.
  task automatic run_contention(input int n);
    bus.if_addr = 32'h0000_0040;
    bus.dm_addr = 32'h0000_0200;
    bus.dm_we   = 1'b0;
    for (int k = 0; k < n; k++) begin
      if (k % 4 == 3) push(1'b0, 1'b0, 32'h40, '0, 32'h1000_0000 + k);
      else            push(1'b1, 1'b0, 32'h200, '0, 32'h2000_0000 + k);
    end
    push(1'b1, 1'b0, 32'h200, '0, 32'h3000_0000);
    bus.if_req = 1'b1;
    bus.dm_req = 1'b1;
    for (int k = 0; k < n; k++) begin
      start_txn();
      finish_txn(0, 1'b1);
    end
    start_txn();
    bus.if_req = 1'b0;
    bus.dm_req = 1'b0;
    finish_txn(0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.if_req = 1'b0; bus.if_addr = '0;
    bus.dm_req = 1'b0; bus.dm_we = 1'b0; bus.dm_addr = '0; bus.dm_wdata = '0;
    bus.mem_ack = 1'b0; bus.mem_rdata = '0;
    Clrn = 1'b0;
    repeat (3) tick();

    // Reset state
    check("rst_mem_req", bus.mem_req, 1'b0);
    check("rst_mem_we", bus.mem_we, 1'b0);
    check("rst_mem_addr", bus.mem_addr, 32'h0);
    check("rst_mem_wdata", bus.mem_wdata, 32'h0);
    check("rst_if_ack", bus.if_ack, 1'b0);
    check("rst_dm_ack", bus.dm_ack, 1'b0);
    check("rst_if_rdata", bus.if_rdata, 32'h0);
    check("rst_dm_rdata", bus.dm_rdata, 32'h0);
    check("rst_bus_err", bus.bus_err, 1'b0);
    check("rst_stall", bus.STALL, 1'b1);
    Clrn = 1'b1;
    tick();

    // IF-only read: mem_req one cycle after the request, held two cycles
    push(1'b0, 1'b0, 32'h40, '0, 32'h8C22_0004);
    bus.if_addr = 32'h40;
    bus.if_req  = 1'b1;
    #1;
    check("if_stall_req", bus.STALL, 1'b0);
    check("if_mem_req_c0", bus.mem_req, 1'b0);
    tick();
    check("if_mem_req_c1", bus.mem_req, 1'b1);
    start_txn();
    finish_txn(1, 1'b0);

    // DM store held for mem_ack two cycles late
    push(1'b1, 1'b1, 32'h100, 32'hDEAD_BEEF, 32'h5555_AAAA);
    bus.dm_addr  = 32'h100;
    bus.dm_wdata = 32'hDEAD_BEEF;
    bus.dm_we    = 1'b1;
    bus.dm_req   = 1'b1;
    tick();
    start_txn();
    finish_txn(2, 1'b0);
    bus.dm_we = 1'b0;

    // Contention: DM,DM,DM,IF,DM,DM,DM,IF
    run_contention(8);

    // Reset during the third contended DM access; the streak must be forgotten
    run_contention(0);
    push(1'b1, 1'b0, 32'h200, '0, 32'h4000_0000);
    push(1'b1, 1'b0, 32'h200, '0, 32'h4000_0001);
    push(1'b1, 1'b0, 32'h200, '0, 32'h4000_0002);
    bus.if_req = 1'b1;
    bus.dm_req = 1'b1;
    start_txn(); finish_txn(0, 1'b1);
    start_txn(); finish_txn(0, 1'b1);
    start_txn();
    tick();
    Clrn = 1'b0;
    bus.if_req = 1'b0;
    bus.dm_req = 1'b0;
    tick();
    Clrn = 1'b1;
    check("rst_mid_mem_req", bus.mem_req, 1'b0);
    check("rst_mid_dm_ack", bus.dm_ack, 1'b0);
    check("rst_mid_stall", bus.STALL, 1'b1);
    bus.mem_ack = 1'b1;
    tick();
    bus.mem_ack = 1'b0;
    check("idle_ack_dm", bus.dm_ack, 1'b0);
    check("idle_ack_if", bus.if_ack, 1'b0);
    check("idle_ack_req", bus.mem_req, 1'b0);
    tick();
    check("idle_ack_dm2", bus.dm_ack, 1'b0);
    run_contention(4);

    // Early drop: DM withdraws right after the grant; transaction still completes
    push(1'b1, 1'b0, 32'h180, '0, 32'hCAFE_F00D);
    bus.dm_addr = 32'h180;
    bus.dm_req  = 1'b1;
    tick();
    start_txn();
    bus.dm_req = 1'b0;
    finish_txn(3, 1'b0);

`ifdef ARB_TIMEOUT_EN
    // No mem_ack: abandoned after BUSY cycle 15
    push(1'b0, 1'b0, 32'h48, '0, 32'h0);
    bus.if_addr = 32'h48;
    bus.if_req  = 1'b1;
    tick();
    start_txn();
    for (int i = 0; i < 14; i++) begin
      tick();
      check("to_mem_req", bus.mem_req, 1'b1);
      check("to_bus_err_early", bus.bus_err, 1'b0);
    end
    tick();
    check("to_bus_err", bus.bus_err, 1'b1);
    check("to_if_ack", bus.if_ack, 1'b1);
    check("to_if_rdata", bus.if_rdata, 32'h0);
    check("to_mem_req_drop", bus.mem_req, 1'b0);
    $display("txn IF timeout addr=0x%08h bus_err=%0d", cur.addr, bus.bus_err);
    bus.if_req = 1'b0;
    tick();
    check("to_bus_err_pulse", bus.bus_err, 1'b0);
    check("to_if_ack_pulse", bus.if_ack, 1'b0);

    // mem_ack in BUSY cycle 15 wins over the timeout
    push(1'b0, 1'b0, 32'h4C, '0, 32'h1234_5678);
    bus.if_addr = 32'h4C;
    bus.if_req  = 1'b1;
    tick();
    start_txn();
    finish_txn(14, 1'b0);
`endif

    tick();
    check("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported unified memory between two requesters: the instruction-fetch stage (IF) and the load/store stage (DM).
- Sequences every memory transaction with a req/ack handshake.
- Drives an active-low STALL that freezes the pipeline while any access is outstanding.
- Sits between the pipeline stage registers and the memory model. DM has priority; a starvation counter guarantees IF progress.

Parameters:
- AW, 32, address width.
- DW, 32, data width.
- STARVE_MAX, 3, consecutive DM grants allowed while IF waits; the next contested slot goes to IF.
- TIMEOUT, 15, cycles allowed for mem_ack; used only with ARB_TIMEOUT_EN.

Ports:
- Clk  in  1  clock; all state updates on the rising edge.
- Clrn  in  1  reset, synchronous, active-low.
- if_req  in  1  fetch request; held until if_ack.
- if_addr  in  AW  fetch address.
- if_rdata  out  DW  fetched word; registered.
- if_ack  out  1  one-cycle completion pulse to IF.
- dm_req  in  1  load/store request; held until dm_ack.
- dm_we  in  1  1 = store.
- dm_addr  in  AW  data address.
- dm_wdata  in  DW  store data.
- dm_rdata  out  DW  load data; registered.
- dm_ack  out  1  one-cycle completion pulse to DM.
- mem_req  out  1  request to memory; held until mem_ack.
- mem_we  out  1  write strobe to memory.
- mem_addr  out  AW  memory address.
- mem_wdata  out  DW  memory write data.
- mem_rdata  in  DW  memory read data; valid with mem_ack.
- mem_ack  in  1  memory completion.
- STALL  out  1  active-low; 0 freezes PC and the IF/ID and ID/EX registers.
- bus_err  out  1  one-cycle timeout pulse; tied 0 without ARB_TIMEOUT_EN.

Behaviour:
- Reset (Clrn=0 at an edge) sets:
  - state=IDLE, starve_cnt=0;
  - mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0;
  - if_ack=0, dm_ack=0, if_rdata=0, dm_rdata=0, bus_err=0.
  - Reset mid-transaction abandons it: mem_req is 0 after that edge and no ack is issued.
- States: IDLE, IF_BUSY, DM_BUSY.
- IDLE grant rule:
  - DM is granted if dm_req=1 and not (if_req=1 and starve_cnt==STARVE_MAX).
  - Otherwise IF is granted if if_req=1.
  - Otherwise the block stays in IDLE.
- On a grant edge:
  - Register mem_addr, mem_we, mem_wdata and set mem_req=1.
  - mem_we = dm_we for DM and 0 for IF.
  - Move to DM_BUSY or IF_BUSY.
- BUSY states:
  - mem_req and the mem_* outputs hold stable until mem_ack=1 is sampled.
  - At that edge: mem_req=0 and mem_we=0; the matching rdata register loads mem_rdata (stores also load it; the value is don't-care); the matching ack is high for exactly the next cycle; return to IDLE.
- Latency:
  - Request seen in cycle 0, mem_req high in cycle 1.
  - mem_ack in cycle k gives the requester ack in cycle k+1.
  - Minimum two cycles from grant to grant: one IDLE cycle between transactions.
- Starvation counter:
  - Increments (saturating at STARVE_MAX) on each DM grant made while if_req=1.
  - Clears on an IF grant, or on any edge with if_req=0.
- Requester dropping req before its ack: the memory transaction still completes and the ack pulse is still issued.
- mem_ack while IDLE is ignored.
- STALL = NOT((if_req AND NOT if_ack) OR (dm_req AND NOT dm_ack)). Purely combinational; 1 in reset.
- Address and data pass through unmodified; no width conversion.

Optional Feature:
- Macro ARB_TIMEOUT_EN.
- Defined:
  - A 4-bit-or-wider wait counter clears on grant and increments each BUSY cycle without mem_ack.
  - When it reaches TIMEOUT: mem_req drops, the granted requester's ack pulses with its rdata=0, bus_err pulses in the same cycle, and the state returns to IDLE.
  - mem_ack arriving in the same cycle as the timeout takes precedence (normal completion, no bus_err).
- Undefined:
  - BUSY waits indefinitely, no counter is built, bus_err is constant 0.

Test Plan:
- IF-only read: if_req=1, if_addr=0x40, mem_ack two cycles after mem_req with mem_rdata=0x8C220004 -> mem_req high 2 cycles, if_ack pulses once, if_rdata=0x8C220004, STALL=0 until the ack cycle.
- DM store: dm_req=1, dm_we=1, dm_addr=0x100, dm_wdata=0xDEADBEEF -> mem_we=1, mem_addr=0x100, mem_wdata=0xDEADBEEF held until mem_ack; dm_ack pulses; if_ack stays 0.
- Contention with STARVE_MAX=3: if_req and dm_req held high, mem_ack on every mem_req -> grant order DM, DM, DM, IF, DM, DM, DM, IF.
- Reset mid-access: Clrn=0 while in DM_BUSY -> next cycle mem_req=0, dm_ack=0, STALL=1, starve_cnt=0; a later mem_ack is ignored.
- Early drop: dm_req falls one cycle after grant -> mem_req stays high until mem_ack, dm_ack still pulses once.
- With ARB_TIMEOUT_EN and TIMEOUT=15: IF grant, mem_ack never arrives -> cycle 15 of BUSY gives bus_err=1, if_ack=1, if_rdata=0, mem_req=0. A second run with mem_ack in cycle 15 gives a normal completion with bus_err=0.
